seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexing driver for a 4-digit, 8-segment (7 segments + dp) display. It sits directly downstream of the BCD-to-segment encoder and takes that encoder's four 8-bit per-digit segment patterns. It scans one digit at a time and inserts a programmable blanking gap between digits to suppress ghosting. New patterns are double-buffered so that a frame never shows a mix of old and new digits.

## Interface
Parameters:
- CLK_DIV, 1000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 50: blanked cycles at the start of each slot; legal range 0 ≤ BLANK_CYCLES < CLK_DIV.
- SEG_ACTIVE_LOW, 1: 1 means o_seg drives 0 for a lit segment.
- DIG_ACTIVE_LOW, 1: 1 means o_dig drives 0 for the enabled digit.

Ports:
- i_clk, input, 1: sole clock; all state changes on its rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_data_0, input, 8: segment pattern for digit 0 (rightmost); bit = 1 means segment lit.
- i_data_1, input, 8: segment pattern for digit 1.
- i_data_2, input, 8: segment pattern for digit 2.
- i_data_3, input, 8: segment pattern for digit 3 (leftmost).
- i_load, input, 1: one-cycle strobe that captures i_data_0..3 into the pending buffer.
- o_seg, output, 8: segment drive, polarity per SEG_ACTIVE_LOW.
- o_dig, output, 4: one-hot digit enable, polarity per DIG_ACTIVE_LOW; bit k selects digit k.
- o_frame, output, 1: one-cycle pulse on cycle 0 of the digit-0 slot.

## Operation
- State:
  - Slot counter cnt runs 0..CLK_DIV-1.
  - Digit index dig runs 0..3.
  - Four 8-bit shadow registers hold the patterns being displayed.
  - Four 8-bit pending registers plus a pend flag hold a queued update.
- Slot sequence:
  - cnt increments every cycle.
  - When cnt reaches CLK_DIV-1 it wraps to 0 and dig advances 0→1→2→3→0.
  - One frame is 4·CLK_DIV cycles.
- Output per cycle:
  - If cnt < BLANK_CYCLES, the slot is blank: every o_dig bit is inactive and every o_seg bit is inactive (unlit).
  - Otherwise the slot is active: o_dig enables only bit dig, and o_seg = shadow[dig], inverted when SEG_ACTIVE_LOW = 1.
- Double buffering:
  - i_load = 1 copies i_data_0..3 into the pending registers and sets pend. A later i_load before the frame boundary overwrites the pending registers; last write wins.
  - The frame boundary is the cycle where dig = 3 and cnt = CLK_DIV-1. On that edge, if pend = 1, the pending registers are copied to the shadow registers and pend is cleared.
  - If i_load is high on the boundary cycle itself, the current i_data values go straight into the shadow registers on that edge and pend ends cleared.
  - i_load has no effect on the timing of cnt or dig.
- Reset (asynchronous, on i_rst high):
  - cnt = 0, dig = 0, shadow = 0, pending = 0, pend = 0.
  - o_seg and o_dig are at their inactive levels: 8'hFF / 4'hF with the default parameters.
  - o_frame = 0.
  - Reset asserted mid-frame discards any pending update.

## Timing
- All outputs are registered. The output values for slot-cycle (dig, cnt) appear on the edge that enters that state.
- After i_rst deasserts, the first rising edge produces dig 0, cnt 0, o_frame = 1, and blank outputs if BLANK_CYCLES > 0.
- With BLANK_CYCLES = 0, each digit is enabled for all CLK_DIV cycles and switches directly to the next digit with no gap.
- An update loaded at any point in frame N first appears on the digit-0 slot of frame N+1. Worst-case load-to-display latency is 4·CLK_DIV + 1 cycles.
- o_frame period is exactly 4·CLK_DIV cycles, high for 1 cycle.
- There is no combinational path from any input to any output.

## Test plan
All scenarios use CLK_DIV = 8, BLANK_CYCLES = 2, and both polarities active-low unless stated.

1. Reset values:
   - Stimulus: assert i_rst asynchronously mid-cycle.
   - Response: o_seg = 8'hFF, o_dig = 4'hF and o_frame = 0 immediately, without waiting for a clock edge.
2. Scan order:
   - Stimulus: i_load with i_data_0..3 = 8'h3F, 8'h06, 8'h5B, 8'h4F, then run 2 frames.
   - Response, second frame slot by slot: o_dig = 1110 with o_seg = 8'hC0; then 1101 with 8'hF9; then 1011 with 8'hA4; then 0111 with 8'hB0.
   - Each slot has 2 blank cycles (o_dig = 4'hF) followed by 6 active cycles.
   - o_frame pulses every 32 cycles.
3. Frame-atomic update:
   - Stimulus: while digit 1 of a frame is being displayed, load 8'h7F on all digits.
   - Response: digits 2 and 3 of the current frame still show the old patterns; the next frame shows o_seg = 8'h80 on every digit.
4. Boundary load:
   - Stimulus: pulse i_load on the cycle where dig = 3 and cnt = 7.
   - Response: the very next digit-0 slot shows the new data.
   - Additional stimulus: a second i_load earlier in the same frame, with different data.
   - Response: the last-write-wins value is displayed.
5. No blanking and polarity:
   - Stimulus: BLANK_CYCLES = 0, SEG_ACTIVE_LOW = 0, DIG_ACTIVE_LOW = 0, data 8'h3F on digit 0.
   - Response: o_dig = 0001 and o_seg = 8'h3F for 8 consecutive cycles, with no all-off cycle between digits.
6. Mid-frame reset:
   - Stimulus: pulse i_rst with a pending update queued at dig = 2.
   - Response: after release, the scan restarts at digit 0 with o_frame = 1, and all digits show 8'hFF (segments unlit) until a new i_load arrives.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed 4-digit, 8-segment display driver.
// Scans one digit per CLK_DIV-cycle slot, blanks the first BLANK_CYCLES of
// each slot, and double-buffers new patterns so updates land on frame edges.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_data_0..i_data_3    per-digit segment patterns (1 = lit), digit 0 right
//   i_load                strobe capturing i_data_* into the pending buffer
//   o_seg                 registered segment drive (polarity SEG_ACTIVE_LOW)
//   o_dig                 registered one-hot digit enable (DIG_ACTIVE_LOW)
//   o_frame               one-cycle pulse on cycle 0 of the digit-0 slot
module seven_segment_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data_0,
  input  logic [7:0] i_data_1,
  input  logic [7:0] i_data_2,
  input  logic [7:0] i_data_3,
  input  logic       i_load,
  output logic [7:0] o_seg,
  output logic [3:0] o_dig,
  output logic       o_frame
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [3:0][7:0] data_in;
  assign data_in = {i_data_3, i_data_2, i_data_1, i_data_0};

  // run_q is clear only between reset release and the first edge, so
  // that first edge enters slot-cycle (0,0) rather than stepping past it.
  logic            run_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic [3:0][7:0] pdata_q, pdata_d;
  logic            pend_q, pend_d;

  logic [7:0]      seg_q, seg_d;
  logic [3:0]      digen_q, digen_d;
  logic            frame_q, frame_d;

  logic            boundary;
  logic            blank_d;
  logic [7:0]      pat_d;
  logic [3:0]      onehot_d;

  // Slot counter, digit index and double-buffer control.
  always_comb begin
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    pdata_d  = pdata_q;
    pend_d   = pend_q;
    boundary = run_q && (dig_q == 2'd3) && (cnt_q == CNT_LAST);

    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        dig_d = dig_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (i_load) begin
      pdata_d = data_in;
      pend_d  = 1'b1;
    end

    // A load on the boundary itself bypasses the pending buffer.
    if (boundary) begin
      if (i_load) begin
        shadow_d = data_in;
      end else if (pend_q) begin
        shadow_d = pdata_q;
      end
      pend_d = 1'b0;
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_d = 1'b0;
    end else begin : g_blank
      assign blank_d = (cnt_d < CW'(BLANK_CYCLES));
    end
  endgenerate

  // Outputs are computed from the next state so they are registered
  // together with the slot-cycle they describe.
  always_comb begin
    pat_d    = shadow_d[dig_d];
    onehot_d = 4'b0001 << dig_d;
    seg_d    = SEG_OFF;
    digen_d  = DIG_OFF;
    if (!blank_d) begin
      seg_d   = SEG_ACTIVE_LOW ? ~pat_d : pat_d;
      digen_d = DIG_ACTIVE_LOW ? ~onehot_d : onehot_d;
    end
    frame_d = (cnt_d == '0) && (dig_d == 2'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      shadow_q <= '0;
      pdata_q  <= '0;
      pend_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      digen_q  <= DIG_OFF;
      frame_q  <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      pdata_q  <= pdata_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      digen_q  <= digen_d;
      frame_q  <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_dig   = digen_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed bench for seven_segment_scanner.
// Two instances: default polarities with blanking, and no-blank active-high.
module tb_seven_segment_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       load = 1'b0;
  logic [7:0] e0 = '0, e1 = '0, e2 = '0, e3 = '0;
  logic       load2 = 1'b0;
  logic [7:0] seg, seg2;
  logic [3:0] dig, dig2;
  logic       frame, frame2;

  int tests = 0;
  int fails = 0;
  int t = -1;
  logic [3:0][7:0] sh;
  logic [3:0][7:0] sh2;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .CLK_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_data_0(d0), .i_data_1(d1), .i_data_2(d2), .i_data_3(d3),
    .i_load(load),
    .o_seg(seg), .o_dig(dig), .o_frame(frame)
  );

  seven_segment_scanner #(
    .CLK_DIV(8), .BLANK_CYCLES(0),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_data_0(e0), .i_data_1(e1), .i_data_2(e2), .i_data_3(e3),
    .i_load(load2),
    .o_seg(seg2), .o_dig(dig2), .o_frame(frame2)
  );

  // Expected outputs for slot-cycle t (t = 0 is the first edge after reset).
  function automatic logic [7:0] m_seg(int tt, logic [3:0][7:0] s);
    int d;
    int c;
    d = (tt / 8) % 4;
    c = tt % 8;
    if (c < 2) return 8'hFF;
    return ~s[d];
  endfunction

  function automatic logic [3:0] m_dig(int tt);
    int d;
    int c;
    logic [3:0] oh;
    d = (tt / 8) % 4;
    c = tt % 8;
    oh = 4'b0001 << d;
    if (c < 2) return 4'hF;
    return ~oh;
  endfunction

  function automatic logic m_frame(int tt);
    return (tt % 32) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t = -1;
    sh = '0;
    sh2 = '0;
  endtask

  task automatic set_data(input logic [7:0] a, b, c, d);
    d0 = a; d1 = b; d2 = c; d3 = d;
  endtask

  task automatic test_scan_order();
    do_reset();
    set_data(8'h3F, 8'h06, 8'h5B, 8'h4F);
    load = 1'b1;
    tick();
    load = 1'b0;
    while (t < 64) begin
      if (t == 32) sh = {8'h4F, 8'h5B, 8'h06, 8'h3F};
      tests++;
      if (seg !== m_seg(t, sh)) begin
        fails++;
        $display("FAIL scan_seg t=%0d got %h exp %h", t, seg, m_seg(t, sh));
      end
      tests++;
      if (dig !== m_dig(t)) begin
        fails++;
        $display("FAIL scan_dig t=%0d got %b exp %b", t, dig, m_dig(t));
      end
      tests++;
      if (frame !== m_frame(t)) begin
        fails++;
        $display("FAIL scan_frame t=%0d got %b exp %b", t, frame, m_frame(t));
      end
      tick();
    end
  endtask

  task automatic test_reset();
    while (t < 66) tick();
    tests++;
    if (seg !== 8'hC0 || dig !== 4'b1110) begin
      fails++;
      $display("FAIL pre_reset got %h/%b exp c0/1110", seg, dig);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (seg !== 8'hFF) begin
      fails++;
      $display("FAIL reset_seg got %h exp ff", seg);
    end
    tests++;
    if (dig !== 4'hF) begin
      fails++;
      $display("FAIL reset_dig got %h exp f", dig);
    end
    tests++;
    if (frame !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame got %b exp 0", frame);
    end
    @(negedge clk);
    rst = 1'b0;
    t = -1;
    sh = '0;
  endtask

  task automatic test_frame_atomic();
    set_data(8'h3F, 8'h06, 8'h5B, 8'h4F);
    load = 1'b1;
    tick();
    load = 1'b0;
    while (t < 42) tick();
    sh = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    set_data(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    load = 1'b1;
    tick();
    load = 1'b0;
    while (t < 96) begin
      if (t == 64) sh = {4{8'h7F}};
      tests++;
      if (seg !== m_seg(t, sh)) begin
        fails++;
        $display("FAIL atomic_seg t=%0d got %h exp %h", t, seg, m_seg(t, sh));
      end
      tests++;
      if (dig !== m_dig(t)) begin
        fails++;
        $display("FAIL atomic_dig t=%0d got %b exp %b", t, dig, m_dig(t));
      end
      tick();
    end
  endtask

  task automatic test_boundary();
    while (t < 100) tick();
    set_data(8'h01, 8'h02, 8'h04, 8'h08);
    load = 1'b1;
    tick();
    load = 1'b0;
    while (t < 127) tick();
    set_data(8'h76, 8'h38, 8'h6D, 8'h66);
    load = 1'b1;
    tick();
    load = 1'b0;
    sh = {8'h66, 8'h6D, 8'h38, 8'h76};
    while (t < 165) begin
      if (t < 160) begin
        tests++;
        if (seg !== m_seg(t, sh)) begin
          fails++;
          $display("FAIL bnd_seg t=%0d got %h exp %h", t, seg, m_seg(t, sh));
        end
        tests++;
        if (frame !== m_frame(t)) begin
          fails++;
          $display("FAIL bnd_frame t=%0d got %b exp %b", t, frame, m_frame(t));
        end
      end
      tick();
    end
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    load = 1'b1;
    tick();
    load = 1'b0;
    while (t < 170) tick();
    set_data(8'h5A, 8'hA5, 8'h0F, 8'hF0);
    load = 1'b1;
    tick();
    load = 1'b0;
    while (t < 224) begin
      if (t == 192) sh = {8'hF0, 8'h0F, 8'hA5, 8'h5A};
      tests++;
      if (seg !== m_seg(t, sh)) begin
        fails++;
        $display("FAIL lww_seg t=%0d got %h exp %h", t, seg, m_seg(t, sh));
      end
      tick();
    end
  endtask

  task automatic test_midframe_reset();
    while (t < 240) tick();
    set_data(8'h49, 8'h49, 8'h49, 8'h49);
    load = 1'b1;
    tick();
    load = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t = -1;
    sh = '0;
    tick();
    while (t < 64) begin
      tests++;
      if (seg !== m_seg(t, sh)) begin
        fails++;
        $display("FAIL mrst_seg t=%0d got %h exp %h", t, seg, m_seg(t, sh));
      end
      tests++;
      if (dig !== m_dig(t)) begin
        fails++;
        $display("FAIL mrst_dig t=%0d got %b exp %b", t, dig, m_dig(t));
      end
      tests++;
      if (frame !== m_frame(t)) begin
        fails++;
        $display("FAIL mrst_frame t=%0d got %b exp %b", t, frame, m_frame(t));
      end
      tick();
    end
  endtask

  task automatic test_no_blank();
    logic [3:0] oh;
    do_reset();
    e0 = 8'h3F; e1 = 8'h00; e2 = 8'h00; e3 = 8'h00;
    load2 = 1'b1;
    tick();
    load2 = 1'b0;
    while (t < 64) begin
      if (t == 32) sh2 = {8'h00, 8'h00, 8'h00, 8'h3F};
      oh = 4'b0001 << ((t / 8) % 4);
      tests++;
      if (dig2 !== oh) begin
        fails++;
        $display("FAIL nb_dig t=%0d got %b exp %b", t, dig2, oh);
      end
      tests++;
      if (seg2 !== sh2[(t / 8) % 4]) begin
        fails++;
        $display("FAIL nb_seg t=%0d got %h exp %h", t, seg2,
                 sh2[(t / 8) % 4]);
      end
      tests++;
      if (frame2 !== m_frame(t)) begin
        fails++;
        $display("FAIL nb_frame t=%0d got %b exp %b", t, frame2, m_frame(t));
      end
      tick();
    end
  endtask

  initial begin
    sh = '0;
    sh2 = '0;
    test_scan_order();
    test_reset();
    test_frame_atomic();
    test_boundary();
    test_midframe_reset();
    test_no_blank();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
